// File: rtl/ssd_capture.sv
`default_nettype none
// ============================================================================
// Module   : ssd_capture
// Purpose  : Receive-side decoder for a two-digit multiplexed seven-segment
//            bus. Synchronises and samples the bus, waits for each select
//            phase to be stable, decodes the segment pattern back to BCD and
//            rebuilds the two-digit value. Flags illegal patterns and a
//            select line that has stopped toggling.
// Ports    : clk        - system clock
//            rst_n      - asynchronous active-low reset
//            ssdsel     - bus select (1 = tens phase, 0 = ones phase)
//            ssdout     - bus segments, bit0 = a ... bit6 = g
//            clr_err    - synchronous clear of err_sticky
//            ones/tens  - last completed pair, BCD
//            pair_valid - 1-cycle pulse when a new pair is loaded
//            changed    - 1-cycle pulse with pair_valid when the value moved
//            seg_err    - 1-cycle pulse on capture of an illegal pattern
//            err_sticky - latched seg_err
//            stalled    - select has not toggled for TIMEOUT_CYCLES
// Revision : 1.0 - initial release
// ============================================================================
module ssd_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ssdsel,
  input  logic [6:0] ssdout,
  input  logic       clr_err,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       pair_valid,
  output logic       changed,
  output logic       seg_err,
  output logic       err_sticky,
  output logic       stalled
);

  // Capture fires in the cycle stab_cnt steps from STABLE_CYCLES-2 to
  // STABLE_CYCLES-1, so the pattern must sit in the sample register for
  // STABLE_CYCLES consecutive cycles.
  localparam logic [7:0]  STAB_LAST = 8'(STABLE_CYCLES - 2);
  localparam logic [19:0] TO_LIMIT  = 20'(TIMEOUT_CYCLES);
  localparam logic [19:0] TO_MAX    = 20'hFFFFF;

  localparam logic [0:0] S_SETTLE = 1'b0;
  localparam logic [0:0] S_HELD   = 1'b1;

  // Input synchroniser, sample and previous-sample registers
  logic       sel_meta, sel_sync, s_sel, p_sel;
  logic [6:0] seg_meta, seg_sync, s_seg, p_seg;

  logic [0:0] state, state_next;
  logic [7:0] stab_cnt;
  logic       capture;
  logic       same;

  logic [6:0] dseg;
  logic [3:0] dec_digit;
  logic       dec_legal;
  logic       cap_legal, cap_illegal;

  logic [3:0] tens_sh, ones_sh;
  logic       got_tens, got_ones;
  logic       pair_done;
  logic       have_pair;

  logic [19:0] to_cnt;
  logic        sel_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_meta <= 1'b0;
      sel_sync <= 1'b0;
      s_sel    <= 1'b0;
      p_sel    <= 1'b0;
      seg_meta <= 7'd0;
      seg_sync <= 7'd0;
      s_seg    <= 7'd0;
      p_seg    <= 7'd0;
    end else begin
      sel_meta <= ssdsel;
      sel_sync <= sel_meta;
      s_sel    <= sel_sync;
      p_sel    <= s_sel;
      seg_meta <= ssdout;
      seg_sync <= seg_meta;
      s_seg    <= seg_sync;
      p_seg    <= s_seg;
    end
  end

  assign same     = ({s_sel, s_seg} == {p_sel, p_seg});
  assign sel_edge = s_sel ^ p_sel;

  generate
    if (SEG_ACTIVE_LOW != 0) begin : g_seg_inv
      assign dseg = ~s_seg;
    end else begin : g_seg_pass
      assign dseg = s_seg;
    end
  endgenerate

  always_comb begin
    dec_legal = 1'b1;
    dec_digit = 4'd0;
    case (dseg)
      7'h3F:   dec_digit = 4'd0;
      7'h06:   dec_digit = 4'd1;
      7'h5B:   dec_digit = 4'd2;
      7'h4F:   dec_digit = 4'd3;
      7'h66:   dec_digit = 4'd4;
      7'h6D:   dec_digit = 4'd5;
      7'h7D:   dec_digit = 4'd6;
      7'h07:   dec_digit = 4'd7;
      7'h7F:   dec_digit = 4'd8;
      7'h6F:   dec_digit = 4'd9;
      default: dec_legal = 1'b0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Phase qualification FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SETTLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_SETTLE: if (capture) state_next = S_HELD;
      S_HELD:   if (!same)   state_next = S_SETTLE;
      default:               state_next = S_SETTLE;
    endcase
  end

  always_comb begin
    capture = 1'b0;
    if ((state == S_SETTLE) && same && (stab_cnt == STAB_LAST)) begin
      capture = 1'b1;
    end
  end

  // Counts only while settling; frozen in HELD until the bus moves again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= 8'd0;
    end else if (!same) begin
      stab_cnt <= 8'd0;
    end else if (state == S_SETTLE) begin
      stab_cnt <= stab_cnt + 8'd1;
    end
  end

  // --------------------------------------------------------------------------
  // Capture into shadow registers and pair assembly
  // --------------------------------------------------------------------------
  assign cap_legal   = capture & dec_legal;
  assign cap_illegal = capture & ~dec_legal;
  assign pair_done   = got_tens & got_ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_sh  <= 4'd0;
      ones_sh  <= 4'd0;
      got_tens <= 1'b0;
      got_ones <= 1'b0;
    end else begin
      if (cap_legal && s_sel) begin
        tens_sh <= dec_digit;
      end
      if (cap_legal && !s_sel) begin
        ones_sh <= dec_digit;
      end
      // A capture landing in the completion cycle must not be lost.
      got_tens <= (got_tens & ~pair_done) | (cap_legal & s_sel);
      got_ones <= (got_ones & ~pair_done) | (cap_legal & ~s_sel);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens       <= 4'd0;
      ones       <= 4'd0;
      pair_valid <= 1'b0;
      changed    <= 1'b0;
      have_pair  <= 1'b0;
    end else begin
      pair_valid <= pair_done;
      changed    <= 1'b0;
      if (pair_done) begin
        tens      <= tens_sh;
        ones      <= ones_sh;
        // The first pair after reset always counts as a change, even 00.
        changed   <= ~have_pair | ({tens_sh, ones_sh} != {tens, ones});
        have_pair <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Error reporting: err_sticky rises with seg_err; a clear coinciding with
  // the seg_err pulse loses to the set.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_err    <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      seg_err    <= cap_illegal;
      err_sticky <= cap_illegal | seg_err | (err_sticky & ~clr_err);
    end
  end

  // --------------------------------------------------------------------------
  // Stall detection on the sampled select line
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= 20'd0;
    end else if (sel_edge) begin
      to_cnt <= 20'd0;
    end else if (to_cnt != TO_MAX) begin
      to_cnt <= to_cnt + 20'd1;
    end
  end

  assign stalled = (to_cnt >= TO_LIMIT);

endmodule
`default_nettype wire

// File: tb/tb_ssd_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ssd_capture
// Purpose  : Directed self-checking bench for ssd_capture. One instance with
//            active-high segments exercises pairing, re-capture, glitch
//            rejection, illegal patterns, stall detection and reset; a second
//            instance with inverted segments checks the inversion path.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssd_capture;

  localparam int S  = 16;
  localparam int TO = 500;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sel, sel1;
  logic [6:0] seg, seg1;
  logic       clr, clr1;

  logic [3:0] ones, tens, ones1, tens1;
  logic       pv, chg, serr, sticky, stl;
  logic       pv1, chg1, serr1, sticky1, stl1;

  int checks  = 0;
  int errors  = 0;
  int pv_cnt  = 0;
  int ch_cnt  = 0;
  int err_cnt = 0;
  int pbase, cbase, ebase;

  always #5 clk = ~clk;

  ssd_capture #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO),
    .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ssdsel    (sel),
    .ssdout    (seg),
    .clr_err   (clr),
    .ones      (ones),
    .tens      (tens),
    .pair_valid(pv),
    .changed   (chg),
    .seg_err   (serr),
    .err_sticky(sticky),
    .stalled   (stl)
  );

  ssd_capture #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO),
    .SEG_ACTIVE_LOW(1)
  ) dut_inv (
    .clk       (clk),
    .rst_n     (rst_n),
    .ssdsel    (sel1),
    .ssdout    (seg1),
    .clr_err   (clr1),
    .ones      (ones1),
    .tens      (tens1),
    .pair_valid(pv1),
    .changed   (chg1),
    .seg_err   (serr1),
    .err_sticky(sticky1),
    .stalled   (stl1)
  );

  always @(negedge clk) begin
    if (pv)   pv_cnt  = pv_cnt + 1;
    if (chg)  ch_cnt  = ch_cnt + 1;
    if (serr) err_cnt = err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one bus state on the main instance and hold it for n cycles.
  // Called at a falling edge; returns at a falling edge.
  task automatic phase(input logic s, input logic [6:0] p, input int n);
    sel = s;
    seg = p;
    repeat (n) @(negedge clk);
  endtask

  task automatic phase_inv(input logic s, input logic [6:0] p, input int n);
    sel1 = s;
    seg1 = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    sel   = 1'b0;
    seg   = 7'h07;
    clr   = 1'b0;
    sel1  = 1'b0;
    seg1  = 7'h00;
    clr1  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_ones",   ones,   0);
    check_val("rst_tens",   tens,   0);
    check_val("rst_pv",     pv,     0);
    check_val("rst_chg",    chg,    0);
    check_val("rst_segerr", serr,   0);
    check_val("rst_sticky", sticky, 0);
    check_val("rst_stall",  stl,    0);
    rst_n = 1'b1;

    // First pair 37 with exact latency: pulse after S+4 edges from bus change
    phase(1'b0, 7'h07, 100);
    phase(1'b1, 7'h4F, S + 3);
    check_val("lat_pv_early", pv, 0);
    @(negedge clk);
    check_val("lat_pv",   pv,   1);
    check_val("lat_chg",  chg,  1);
    check_val("lat_tens", tens, 3);
    check_val("lat_ones", ones, 7);
    repeat (100 - S - 4) @(negedge clk);

    // Steady 37: one pair per two phases, no change pulses
    pbase = pv_cnt;
    cbase = ch_cnt;
    phase(1'b0, 7'h07, 100);
    phase(1'b1, 7'h4F, 100);
    phase(1'b0, 7'h07, 100);
    phase(1'b1, 7'h4F, 100);
    check_val("steady_pv",   pv_cnt - pbase, 2);
    check_val("steady_chg",  ch_cnt - cbase, 0);
    check_val("steady_tens", tens, 3);
    check_val("steady_ones", ones, 7);

    // Ones pattern changes without a select toggle: re-captured as 8
    pbase = pv_cnt;
    cbase = ch_cnt;
    phase(1'b0, 7'h07, 50);
    phase(1'b0, 7'h7F, 100);
    phase(1'b1, 7'h4F, 100);
    check_val("recap_pv",   pv_cnt - pbase, 1);
    check_val("recap_chg",  ch_cnt - cbase, 1);
    check_val("recap_ones", ones, 8);
    check_val("recap_tens", tens, 3);

    // Glitch of S-1 cycles is ignored; exactly S cycles is captured
    phase(1'b1, 7'h66, 100);
    pbase = pv_cnt;
    phase(1'b0, 7'h06, S - 1);
    phase(1'b1, 7'h66, 100);
    check_val("glitch_pv",   pv_cnt - pbase, 0);
    check_val("glitch_tens", tens, 3);
    pbase = pv_cnt;
    phase(1'b0, 7'h06, S);
    phase(1'b1, 7'h66, 100);
    check_val("edge_pv",   pv_cnt - pbase, 1);
    check_val("edge_ones", ones, 1);
    check_val("edge_tens", tens, 4);

    // Illegal blank in the tens phase
    phase(1'b0, 7'h06, 100);
    pbase = pv_cnt;
    ebase = err_cnt;
    phase(1'b1, 7'h00, S + 3);
    check_val("ill_segerr", serr,   1);
    check_val("ill_sticky", sticky, 1);
    @(negedge clk);
    check_val("ill_pulse_end", serr,   0);
    check_val("ill_sticky_hold", sticky, 1);
    repeat (100 - S - 4) @(negedge clk);
    check_val("ill_errcnt", err_cnt - ebase, 1);
    check_val("ill_pv",     pv_cnt - pbase, 0);
    check_val("ill_tens",   tens, 4);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check_val("clr_sticky", sticky, 0);

    // Clear coinciding with a new seg_err: set wins
    phase(1'b0, 7'h00, S + 3);
    check_val("both_segerr", serr, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("both_sticky", sticky, 1);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_val("both_clr", sticky, 0);

    // Stall detection with its exact threshold
    phase(1'b0, 7'h6D, 100);
    phase(1'b1, 7'h5B, TO + 3);
    check_val("stall_early", stl, 0);
    check_val("stall_tens",  tens, 2);
    check_val("stall_ones",  ones, 5);
    @(negedge clk);
    check_val("stall_set", stl, 1);
    phase(1'b1, 7'h6F, 50);
    check_val("stall_hold", stl, 1);
    phase(1'b0, 7'h7D, 4);
    check_val("stall_clear", stl, 0);
    repeat (96) @(negedge clk);
    check_val("stall_cap_tens", tens, 9);
    check_val("stall_cap_ones", ones, 6);

    // Inverted segments on the second instance: ~4F = 30, ~6D = 12
    phase_inv(1'b1, 7'h30, 100);
    phase_inv(1'b0, 7'h12, 100);
    phase_inv(1'b1, 7'h30, 100);
    check_val("inv_ones",   ones1,   5);
    check_val("inv_tens",   tens1,   3);
    check_val("inv_sticky", sticky1, 0);

    // Reset mid-phase, with tens already held in the shadow register
    phase(1'b1, 7'h06, 100);
    phase(1'b0, 7'h3F, 10);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_ones",  ones,   0);
    check_val("arst_tens",  tens,   0);
    check_val("arst_pv",    pv,     0);
    check_val("arst_chg",   chg,    0);
    check_val("arst_stall", stl,    0);
    @(negedge clk);
    rst_n = 1'b1;
    pbase = pv_cnt;
    cbase = ch_cnt;
    phase(1'b0, 7'h3F, 100);
    check_val("arst_discard", pv_cnt - pbase, 0);
    phase(1'b1, 7'h3F, 100);
    check_val("arst_pv_cnt",  pv_cnt - pbase, 1);
    check_val("arst_chg_cnt", ch_cnt - cbase, 1);
    check_val("arst_new_tens", tens, 0);
    check_val("arst_new_ones", ones, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
